// File: rtl/tff_seq.sv
// Sequencer for a downstream toggle-flip-flop cell: reset pulse, a burst of
// write (toggle) pulses, then a read window that captures the cell state.
module tff_seq #(
  parameter int RST_CYC = 4,
  parameter int GAP_CYC = 1,
  parameter int RD_CYC  = 4
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       start,
  input  logic [7:0] count,
  output logic       busy,
  output logic       done,
  output logic       tff_rstb,
  output logic       tff_we,
  output logic       tff_re,
  input  logic       tff_out,
  input  logic       tff_carry,
  output logic       result,
  output logic [7:0] carry_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RST   = 3'd1,
    WR_HI = 3'd2,
    WR_LO = 3'd3,
    READ  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [3:0] RST_LAST = 4'(RST_CYC - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);
  localparam logic [3:0] RD_LAST  = 4'(RD_CYC - 1);

  state_t     state_q, state_d;
  logic [3:0] cyc_q, cyc_d;
  logic [7:0] rem_q, rem_d;

  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       tff_rstb_q, tff_rstb_d;
  logic       tff_we_q, tff_we_d;
  logic       tff_re_q, tff_re_d;

  logic       out_q, out_d;
  logic       carry_q, carry_d;
  logic       carry_prev_q, carry_prev_d;
  logic       re_dly_q, re_dly_d;
  logic       result_q, result_d;
  logic [7:0] carry_cnt_q, carry_cnt_d;

  logic       accept;
  logic       carry_edge;
  logic       carry_window;

  assign accept       = (state_q == IDLE) && start;
  assign carry_edge   = carry_q && !carry_prev_q;
  assign carry_window = (state_q == WR_HI) || (state_q == WR_LO) || (state_q == READ);

  always_ff @(posedge clk) begin
    if (rstb) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      rem_q   <= rem_d;
    end
  end

  // cyc_q counts cycles already spent in the current timed state
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RST;
          cyc_d   = '0;
          rem_d   = count;
        end
      end
      RST: begin
        if (cyc_q == RST_LAST) begin
          state_d = (rem_q != 8'd0) ? WR_HI : READ;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 4'd1;
        end
      end
      WR_HI: begin
        rem_d   = rem_q - 8'd1;
        state_d = WR_LO;
        cyc_d   = '0;
      end
      WR_LO: begin
        if (cyc_q == GAP_LAST) begin
          state_d = (rem_q != 8'd0) ? WR_HI : READ;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 4'd1;
        end
      end
      READ: begin
        if (cyc_q == RD_LAST) begin
          state_d = DONE;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cyc_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with state_q
  always_comb begin
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    tff_rstb_d = (state_d == RST);
    tff_we_d   = (state_d == WR_HI);
    tff_re_d   = (state_d == READ);
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tff_rstb_q <= 1'b0;
      tff_we_q   <= 1'b0;
      tff_re_q   <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      done_q     <= done_d;
      tff_rstb_q <= tff_rstb_d;
      tff_we_q   <= tff_we_d;
      tff_re_q   <= tff_re_d;
    end
  end

  // Cell outputs are sampled once; re_dly_q marks which out_q samples belong to the read window
  always_comb begin
    out_d        = tff_out;
    carry_d      = tff_carry;
    carry_prev_d = carry_q;
    re_dly_d     = tff_re_q;
    result_d     = result_q;
    carry_cnt_d  = carry_cnt_q;
    if (accept) begin
      result_d    = 1'b0;
      carry_cnt_d = '0;
    end else begin
      if (re_dly_q) begin
        result_d = result_q | out_q;
      end
      if (carry_window && carry_edge && (carry_cnt_q != 8'hFF)) begin
        carry_cnt_d = carry_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      out_q        <= 1'b0;
      carry_q      <= 1'b0;
      carry_prev_q <= 1'b0;
      re_dly_q     <= 1'b0;
      result_q     <= 1'b0;
      carry_cnt_q  <= '0;
    end else begin
      out_q        <= out_d;
      carry_q      <= carry_d;
      carry_prev_q <= carry_prev_d;
      re_dly_q     <= re_dly_d;
      result_q     <= result_d;
      carry_cnt_q  <= carry_cnt_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign tff_rstb  = tff_rstb_q;
  assign tff_we    = tff_we_q;
  assign tff_re    = tff_re_q;
  assign result    = result_q;
  assign carry_cnt = carry_cnt_q;

endmodule

// File: tb/tb_tff_seq.sv
// Directed bench for tff_seq driving a behavioural toggle-flip-flop cell.
module tb_tff_seq;

  logic       clk = 1'b0;
  logic       rstb;
  logic       start;
  logic [7:0] count;
  logic       busy, done, tff_rstb, tff_we, tff_re;
  logic       tff_out, tff_carry;
  logic       result;
  logic [7:0] carry_cnt;

  logic cell_state = 1'b0;
  logic cell_carry = 1'b0;

  int tests = 0;
  int fails = 0;
  int we_cnt, rst_cnt, re_cnt, done_cnt;

  tff_seq #(.RST_CYC(4), .GAP_CYC(1), .RD_CYC(4)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .start     (start),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .tff_rstb  (tff_rstb),
    .tff_we    (tff_we),
    .tff_re    (tff_re),
    .tff_out   (tff_out),
    .tff_carry (tff_carry),
    .result    (result),
    .carry_cnt (carry_cnt)
  );

  always #5 clk = ~clk;

  // Cell: reset clears, each write toggles, carry pulses for one cycle on a 1->0 toggle
  always @(posedge clk) begin
    if (tff_rstb) begin
      cell_state <= 1'b0;
      cell_carry <= 1'b0;
    end else if (tff_we) begin
      cell_carry <= cell_state;
      cell_state <= ~cell_state;
    end else begin
      cell_carry <= 1'b0;
    end
  end

  assign tff_out   = cell_state & tff_re;
  assign tff_carry = cell_carry;

  task automatic check_output(input string tag, input int observed, input int expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance one cycle, sample at the falling edge and check pulse exclusivity
  task automatic step();
    int hot;
    @(negedge clk);
    hot = int'(tff_rstb) + int'(tff_we) + int'(tff_re);
    tests++;
    assert (hot <= 1)
    else begin
      fails++;
      $error("[TB] FAIL exclusive observed=%0d expected<=1", hot);
    end
    we_cnt   += int'(tff_we);
    rst_cnt  += int'(tff_rstb);
    re_cnt   += int'(tff_re);
    done_cnt += int'(done);
  endtask

  task automatic apply_stimulus(input string tag, input logic [7:0] c, input int inject_at,
                                input int exp_len, input int exp_we,
                                input int exp_result, input int exp_carry);
    int n;
    we_cnt = 0; rst_cnt = 0; re_cnt = 0; done_cnt = 0;
    start = 1'b1;
    count = c;
    step();
    start = 1'b0;
    count = 8'd200;
    n = 1;
    while (done !== 1'b1 && n < exp_len + 20) begin
      if (n == inject_at) begin
        start = 1'b1;
        count = 8'd9;
      end else if (n == inject_at + 1) begin
        start = 1'b0;
      end
      step();
      n++;
    end
    check_output({tag, "_done"}, int'(done), 1);
    check_output({tag, "_len"}, n, exp_len);
    check_output({tag, "_busy_at_done"}, int'(busy), 1);
    check_output({tag, "_we_pulses"}, we_cnt, exp_we);
    check_output({tag, "_rst_cycles"}, rst_cnt, 4);
    check_output({tag, "_re_cycles"}, re_cnt, 4);
    step();
    check_output({tag, "_done_single"}, int'(done), 0);
    check_output({tag, "_busy_after"}, int'(busy), 0);
    check_output({tag, "_result"}, int'(result), exp_result);
    check_output({tag, "_carry_cnt"}, int'(carry_cnt), exp_carry);
  endtask

  initial begin
    rstb  = 1'b1;
    start = 1'b0;
    count = 8'd0;
    repeat (3) step();
    check_output("rst_busy", int'(busy), 0);
    check_output("rst_done", int'(done), 0);
    check_output("rst_tff_rstb", int'(tff_rstb), 0);
    check_output("rst_tff_we", int'(tff_we), 0);
    check_output("rst_tff_re", int'(tff_re), 0);
    check_output("rst_result", int'(result), 0);
    check_output("rst_carry_cnt", int'(carry_cnt), 0);
    rstb = 1'b0;
    step();

    apply_stimulus("cnt3", 8'd3, 0, 15, 3, 1, 1);
    apply_stimulus("cnt0", 8'd0, 0, 9, 0, 0, 0);
    apply_stimulus("cnt4_restart", 8'd4, 3, 17, 4, 0, 2);
    apply_stimulus("cnt1_after_restart", 8'd1, 0, 11, 1, 1, 0);

    // Abort a count=10 run in its first WR_LO cycle, with start also asserted
    we_cnt = 0; rst_cnt = 0; re_cnt = 0; done_cnt = 0;
    start = 1'b1;
    count = 8'd10;
    step();
    start = 1'b0;
    repeat (4) step();
    check_output("abort_wr_hi_we", int'(tff_we), 1);
    step();
    check_output("abort_wr_lo_we", int'(tff_we), 0);
    check_output("abort_wr_lo_busy", int'(busy), 1);
    rstb  = 1'b1;
    start = 1'b1;
    count = 8'd5;
    step();
    check_output("abort_busy", int'(busy), 0);
    check_output("abort_done", int'(done), 0);
    check_output("abort_tff_rstb", int'(tff_rstb), 0);
    check_output("abort_tff_we", int'(tff_we), 0);
    check_output("abort_tff_re", int'(tff_re), 0);
    check_output("abort_result", int'(result), 0);
    check_output("abort_carry_cnt", int'(carry_cnt), 0);
    rstb  = 1'b0;
    start = 1'b0;
    we_cnt = 0; done_cnt = 0;
    repeat (5) step();
    check_output("abort_idle_busy", int'(busy), 0);
    check_output("abort_no_we", we_cnt, 0);
    check_output("abort_no_done", done_cnt, 0);
    apply_stimulus("cnt1_after_abort", 8'd1, 0, 11, 1, 1, 0);

    apply_stimulus("cnt255", 8'd255, 0, 519, 255, 1, 127);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
